// File: rtl/my32cpu_multicycle_if.sv
// Shared instruction/data memory port: single outstanding request, completed by ack.
interface my32cpu_multicycle_if #(
   parameter int ADDR_W = 32
);
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;
   logic              mem_ack;

   modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ack);
   modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ack);
endinterface

// File: rtl/my32cpu_multicycle.sv
// Multi-cycle MY32CPU: FETCH/DECODE/EXEC/MEM/WB sequenced over one req/ack memory port.
module my32cpu_multicycle #(
   parameter int          NREG     = 32,
   parameter logic [31:0] RESET_PC = 32'h0,
   parameter int          ADDR_W   = 32
) (
   input  logic                 CLK,
   input  logic                 RST,
   my32cpu_multicycle_if.master mem,
   output logic [31:0]          pc_out,
   output logic                 retire,
   output logic                 halted
);
   localparam int IW = $clog2(NREG);
   localparam logic [5:0] OP_R    = 6'h00, OP_J   = 6'h02, OP_BEQ = 6'h04, OP_BNE  = 6'h05,
                          OP_ADDI = 6'h08, OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_LUI = 6'h0F,
                          OP_LW   = 6'h23, OP_SW  = 6'h2B, OP_HALT = 6'h3F;

   typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d;
   logic [31:0] imm_q, imm_d, addr_q, addr_d, res_q, res_d;
   logic        retire_q, retire_d;
   logic [31:0] rf_q [NREG];
   logic        rf_we;
   logic [4:0]  rf_wa;
   logic [5:0]  op, funct;
   logic [4:0]  rs, rt, rd, shamt;
   logic [31:0] pc4, rs_val, rt_val;
   logic        taken;

   assign op    = ir_q[31:26];
   assign rs    = ir_q[25:21];
   assign rt    = ir_q[20:16];
   assign rd    = ir_q[15:11];
   assign shamt = ir_q[10:6];
   assign funct = ir_q[5:0];
   assign pc4   = pc_q + 32'd4;
   assign taken = (op == OP_BEQ) ? (a_q == b_q) : (a_q != b_q);

   // Indices past NREG alias nothing: they read as zero.
   always_comb begin
      rs_val = '0;
      rt_val = '0;
      if (rs != 5'd0 && 32'(rs) < NREG) rs_val = rf_q[rs[IW-1:0]];
      if (rt != 5'd0 && 32'(rt) < NREG) rt_val = rf_q[rt[IW-1:0]];
   end

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      ir_d     = ir_q;
      a_d      = a_q;
      b_d      = b_q;
      imm_d    = imm_q;
      addr_d   = addr_q;
      res_d    = res_q;
      retire_d = 1'b0;
      rf_we    = 1'b0;
      rf_wa    = (op == OP_R) ? rd : rt;
      case (state_q)
         S_FETCH: if (mem.mem_ack) begin
            ir_d    = mem.mem_rdata;
            state_d = S_DECODE;
         end
         S_DECODE: begin
            a_d     = rs_val;
            b_d     = rt_val;
            imm_d   = (op == OP_ANDI || op == OP_ORI) ? {16'h0, ir_q[15:0]}
                                                     : {{16{ir_q[15]}}, ir_q[15:0]};
            state_d = S_EXEC;
         end
         S_EXEC: begin
            state_d = S_WB;
            case (op)
               OP_R: case (funct)
                  6'h20:   res_d = a_q + b_q;
                  6'h22:   res_d = a_q - b_q;
                  6'h24:   res_d = a_q & b_q;
                  6'h25:   res_d = a_q | b_q;
                  6'h26:   res_d = a_q ^ b_q;
                  6'h2A:   res_d = {31'h0, $signed(a_q) < $signed(b_q)};
                  6'h00:   res_d = b_q << shamt;
                  6'h02:   res_d = b_q >> shamt;
                  default: begin pc_d = pc4; retire_d = 1'b1; state_d = S_FETCH; end
               endcase
               OP_ADDI: res_d = a_q + imm_q;
               OP_ANDI: res_d = a_q & imm_q;
               OP_ORI:  res_d = a_q | imm_q;
               OP_LUI:  res_d = {ir_q[15:0], 16'h0};
               OP_LW, OP_SW: begin
                  addr_d  = a_q + imm_q;
                  state_d = S_MEM;
               end
               OP_BEQ, OP_BNE: begin
                  pc_d     = taken ? pc4 + {imm_q[29:0], 2'b00} : pc4;
                  retire_d = 1'b1;
                  state_d  = S_FETCH;
               end
               OP_J: begin
                  pc_d     = {pc4[31:28], ir_q[25:0], 2'b00};
                  retire_d = 1'b1;
                  state_d  = S_FETCH;
               end
               OP_HALT: state_d = S_HALT;
               default: begin pc_d = pc4; retire_d = 1'b1; state_d = S_FETCH; end
            endcase
         end
         S_MEM: if (mem.mem_ack) begin
            if (op == OP_SW) begin
               pc_d     = pc4;
               retire_d = 1'b1;
               state_d  = S_FETCH;
            end else begin
               res_d   = mem.mem_rdata;
               state_d = S_WB;
            end
         end
         S_WB: begin
            rf_we    = 1'b1;
            pc_d     = pc4;
            retire_d = 1'b1;
            state_d  = S_FETCH;
         end
         default: state_d = S_HALT;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q  <= S_FETCH;
         pc_q     <= RESET_PC;
         ir_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         imm_q    <= '0;
         addr_q   <= '0;
         res_q    <= '0;
         retire_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         ir_q     <= ir_d;
         a_q      <= a_d;
         b_q      <= b_d;
         imm_q    <= imm_d;
         addr_q   <= addr_d;
         res_q    <= res_d;
         retire_q <= retire_d;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      end else if (rf_we && rf_wa != 5'd0 && 32'(rf_wa) < NREG) begin
         rf_q[rf_wa[IW-1:0]] <= res_q;
      end
   end

   // RST gates the request combinationally so an in-flight access is withdrawn at once.
   assign mem.mem_req   = !RST && (state_q == S_FETCH || state_q == S_MEM);
   assign mem.mem_we    = !RST && state_q == S_MEM && op == OP_SW;
   assign mem.mem_addr  = RST ? '0 : (state_q == S_MEM ? addr_q[ADDR_W-1:0] : pc_q[ADDR_W-1:0]);
   assign mem.mem_wdata = b_q;
   assign pc_out        = pc_q;
   assign retire        = retire_q;
   assign halted        = (state_q == S_HALT);
endmodule
